// File: rtl/program_loader_pkg.sv
// Shared types and widths for the byte-stream program loader.
package program_loader_pkg;

  localparam int unsigned ByteWidth  = 8;
  localparam int unsigned AddrWidth  = 8;
  localparam int unsigned DataWidth  = 16;
  localparam int unsigned CountWidth = 9;

  localparam logic [DataWidth-1:0] HaltWordDefault = 16'hF800;

  typedef enum logic [2:0] {
    StIdle,
    StGetHi,
    StGetLo,
    StWrite,
    StFinish
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic                  start;
  logic                  byte_valid;
  logic [ByteWidth-1:0]  byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [AddrWidth-1:0]  mem_addr;
  logic [DataWidth-1:0]  mem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic [CountWidth-1:0] word_count;
  logic                  truncated;
  logic                  timeout_err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
    input  word_count, truncated, timeout_err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
    output word_count, truncated, timeout_err
  );

endinterface

// File: rtl/loader_gap_timer.sv
// Counts idle cycles between the two bytes of a word; flags expiry on the
// GAP_TIMEOUT-th consecutive idle cycle.
module loader_gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [15:0] r_cnt;

  assign expired = tick && (r_cnt == 16'(GAP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (tick && !expired) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Assembles high/low byte pairs into 16-bit instruction words and writes them to
// consecutive memory addresses until HALT_WORD, address 0xFF, or a byte-gap timeout.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [DataWidth-1:0] HALT_WORD   = HaltWordDefault,
  parameter int unsigned          GAP_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus
);

  state_e                r_state;
  logic [AddrWidth-1:0]  r_ptr;
  logic [ByteWidth-1:0]  r_hi;
  logic [AddrWidth-1:0]  r_mem_addr;
  logic [DataWidth-1:0]  r_mem_wdata;
  logic [CountWidth-1:0] r_word_count;
  logic                  r_truncated;
  logic                  r_timeout_err;

  logic w_ready;
  logic w_accept;
  logic w_gap_clear;
  logic w_gap_tick;
  logic w_gap_expired;

  assign w_ready     = (r_state == StGetHi) || (r_state == StGetLo);
  assign w_accept    = bus.byte_valid && w_ready;
  assign w_gap_clear = (r_state == StGetHi) && w_accept;
  assign w_gap_tick  = (r_state == StGetLo) && !w_accept;

  loader_gap_timer #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_gap_clear),
    .tick    (w_gap_tick),
    .expired (w_gap_expired)
  );

  // mem_addr/mem_wdata are captured on low-byte accept so they stay stable
  // outside WRITE even while the pointer moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_ptr         <= '0;
      r_hi          <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_word_count  <= '0;
      r_truncated   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_ptr         <= '0;
            r_word_count  <= '0;
            r_truncated   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_state       <= StGetHi;
          end
        end
        StGetHi: begin
          if (w_accept) begin
            r_hi    <= bus.byte_data;
            r_state <= StGetLo;
          end
        end
        StGetLo: begin
          if (w_accept) begin
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= {r_hi, bus.byte_data};
            r_state     <= StWrite;
          end else if (w_gap_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= StIdle;
          end
        end
        StWrite: begin
          r_word_count <= r_word_count + 9'd1;
          if (r_mem_wdata == HALT_WORD) begin
            r_state <= StFinish;
          end else if (r_ptr == '1) begin
            r_truncated <= 1'b1;
            r_state     <= StFinish;
          end else begin
            r_ptr   <= r_ptr + 8'd1;
            r_state <= StGetHi;
          end
        end
        StFinish: r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  assign bus.byte_ready  = w_ready;
  assign bus.mem_we      = (r_state == StWrite);
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.cpu_hold    = (r_state != StIdle);
  assign bus.done        = (r_state == StFinish);
  assign bus.word_count  = r_word_count;
  assign bus.truncated   = r_truncated;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table-driven loads plus hand-written
// sequences for truncation, timeout, reset and stray-start cases.
module tb_program_loader;
  import program_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader #(
    .HALT_WORD   (16'hF800),
    .GAP_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] word;
    int          g_hi;
    int          g_lo;
    logic [7:0]  addr;
  } vec_t;

  vec_t prog [6];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0]  wr_addr [$];
  logic [15:0] wr_data [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_wdata);
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.truncated,
            bus.timeout_err, bus.word_count, bus.mem_addr};
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready_wait", {31'd0, bus.byte_ready}, 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int g_hi, input int g_lo,
                           input logic [7:0] exp_addr);
    send_byte(w[15:8], g_hi);
    send_byte(w[7:0], g_lo);
    check("we_latency", {31'd0, bus.mem_we}, 32'd1);
    check("mem_addr", {24'd0, bus.mem_addr}, {24'd0, exp_addr});
    check("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, w});
  endtask

  task automatic run_prog(input int base, input bit rnd);
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      if (rnd)
        send_word(prog[base+i].word, $urandom_range(0, 15), $urandom_range(0, 15),
                  prog[base+i].addr);
      else
        send_word(prog[base+i].word, prog[base+i].g_hi, prog[base+i].g_lo, prog[base+i].addr);
    end
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("done_clear", {31'd0, bus.done}, 32'd0);
    check("hold_release", {31'd0, bus.cpu_hold}, 32'd0);
    check("word_count3", {23'd0, bus.word_count}, 32'd3);
    check("truncated0", {31'd0, bus.truncated}, 32'd0);
    check("timeout0", {31'd0, bus.timeout_err}, 32'd0);
    check("write_count", wr_data.size(), 32'd3);
    for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
      check("log_addr", {24'd0, wr_addr[i]}, {24'd0, prog[base+i].addr});
      check("log_data", {16'd0, wr_data[i]}, {16'd0, prog[base+i].word});
    end
    check("done_count", done_cnt, 32'd1);
  endtask

  initial begin
    prog[0] = '{16'h4A0A, 0, 0, 8'h00};
    prog[1] = '{16'h4E02, 0, 0, 8'h01};
    prog[2] = '{16'hF800, 0, 0, 8'h02};
    prog[3] = '{16'h4A0A, 7, 15, 8'h00};
    prog[4] = '{16'h4E02, 15, 0, 8'h01};
    prog[5] = '{16'hF800, 3, 15, 8'h02};

    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state and quiet outputs after release.
    repeat (3) @(negedge clk);
    check("reset_outs", {9'd0, outs()}, 32'd0);
    check("reset_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_outs", {9'd0, outs()}, 32'd0);

    // Basic load, then the same words with hand-picked and random byte gaps.
    run_prog(0, 1'b0);
    repeat (4) @(negedge clk);
    check("wc_hold_idle", {23'd0, bus.word_count}, 32'd3);
    run_prog(3, 1'b0);
    run_prog(0, 1'b1);

    // Gap timeout: 15 idle cycles survive, the 16th aborts.
    clear_log();
    pulse_start();
    send_byte(8'h4A, 0);
    repeat (15) @(negedge clk);
    check("gap15_hold", {31'd0, bus.cpu_hold}, 32'd1);
    check("gap15_no_err", {31'd0, bus.timeout_err}, 32'd0);
    @(negedge clk);
    check("timeout_err", {31'd0, bus.timeout_err}, 32'd1);
    check("timeout_idle", {31'd0, bus.cpu_hold}, 32'd0);
    check("timeout_ready", {31'd0, bus.byte_ready}, 32'd0);
    @(negedge clk);
    check("timeout_no_write", wr_data.size(), 32'd0);
    check("timeout_no_done", done_cnt, 32'd0);
    check("timeout_wc", {23'd0, bus.word_count}, 32'd0);

    // 256 non-halt words: truncation at address FF.
    clear_log();
    pulse_start();
    check("start_clears_err", {31'd0, bus.timeout_err}, 32'd0);
    for (int i = 0; i < 256; i++) send_word(16'h0000, 0, 0, 8'(i));
    @(negedge clk);
    check("trunc_done", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("truncated1", {31'd0, bus.truncated}, 32'd1);
    check("word_count256", {23'd0, bus.word_count}, 32'd256);
    check("trunc_writes", wr_data.size(), 32'd256);
    for (int i = 0; i < 256 && i < wr_addr.size(); i++)
      check("trunc_addr", {24'd0, wr_addr[i]}, i);
    check("trunc_done_count", done_cnt, 32'd1);

    // Asynchronous reset mid-load discards everything.
    clear_log();
    pulse_start();
    send_word(16'h1111, 0, 0, 8'h00);
    send_word(16'h2222, 0, 0, 8'h01);
    send_byte(8'h33, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {9'd0, outs()}, 32'd0);
    check("async_reset_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_quiet", {9'd0, outs()}, 32'd0);
    clear_log();
    pulse_start();
    send_word(16'h1234, 0, 0, 8'h00);
    send_word(16'hF800, 0, 0, 8'h01);
    @(negedge clk);
    check("reload_done", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("reload_wc", {23'd0, bus.word_count}, 32'd2);
    check("reload_writes", wr_data.size(), 32'd2);

    // Stray start while waiting for the low byte.
    clear_log();
    pulse_start();
    send_byte(8'h4A, 0);
    pulse_start();
    check("stray_start_hold", {31'd0, bus.cpu_hold}, 32'd1);
    check("stray_start_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_byte(8'h0A, 1);
    check("stray_we", {31'd0, bus.mem_we}, 32'd1);
    check("stray_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("stray_wdata", {16'd0, bus.mem_wdata}, 32'h4A0A);
    send_word(16'hF800, 0, 0, 8'h01);
    @(negedge clk);
    check("stray_done", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("stray_wc", {23'd0, bus.word_count}, 32'd2);
    check("stray_done_count", done_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter HALT_WORD, default 16'hF800: the instruction word that terminates a load.
REQ-002 Parameter GAP_TIMEOUT, default 16: maximum idle cycles allowed between the high and low byte of one word (range 2..65535).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 byte_valid  input  1  byte_data holds a valid byte.
REQ-007 byte_data  input  8  incoming program byte; high byte of each word first.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  8  instruction-memory word address.
REQ-011 mem_wdata  output  16  instruction word to write.
REQ-012 cpu_hold  output  1  CPU held in reset/stall while loading.
REQ-013 done  output  1  one-cycle pulse at load completion.
REQ-014 word_count  output  9  words written in the current/last load (0..256).
REQ-015 truncated  output  1  sticky: load ended at address 8'hFF without HALT_WORD.
REQ-016 timeout_err  output  1  sticky: byte-gap timeout aborted the load.

Function
REQ-017 The FSM SHALL have states IDLE, GET_HI, GET_LO, WRITE, FINISH.
REQ-018 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 exactly in GET_HI and GET_LO.
REQ-019 In IDLE, start=1 SHALL clear the address pointer, word_count, truncated and timeout_err, and move to GET_HI next cycle.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 Accepting a byte in GET_HI SHALL latch it as bits [15:8] and move to GET_LO; accepting in GET_LO SHALL latch bits [7:0] and move to WRITE.
REQ-022 In WRITE, for exactly one cycle, mem_we SHALL be 1, mem_addr SHALL equal the pointer, and mem_wdata SHALL equal {hi,lo}; word_count SHALL increment on the following edge.
REQ-023 Write latency SHALL be exactly one cycle: mem_we asserts in the cycle after the low byte is accepted.
REQ-024 After WRITE: if the word equals HALT_WORD, go to FINISH; else if the pointer is 8'hFF, set truncated and go to FINISH; else increment the pointer and go to GET_HI.
REQ-025 HALT_WORD SHALL itself be written to memory before termination.
REQ-026 FINISH SHALL last one cycle with done=1, then return to IDLE.
REQ-027 A gap counter SHALL clear on entry to GET_LO and count each GET_LO cycle without an accepted byte; upon reaching GAP_TIMEOUT, set timeout_err and go to IDLE with no write and no done pulse.
REQ-028 GET_HI SHALL wait indefinitely (no timeout between words).
REQ-029 cpu_hold SHALL be 1 in every state except IDLE.
REQ-030 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata SHALL hold their last values while mem_we=0.
REQ-031 word_count, truncated and timeout_err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-032 rst_n=0 SHALL immediately force the FSM to IDLE and drive every output to 0, including mid-load; the partially assembled word SHALL be discarded.
REQ-033 After reset release, no output SHALL change until start is accepted.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration, the HALT_WORD default, and the address/data/count widths (8/16/9).
REQ-035 The byte-gap counter SHALL be a separate sub-module, loader_gap_timer (inputs clear, tick; output expired).

Verification
REQ-036 start, bytes 4A 0A 4E 02 F8 00 with no gaps -> writes [00]=4A0A, [01]=4E02, [02]=F800; done pulse one cycle after the third write; word_count=3; truncated=0.
REQ-037 256 words of 0000 -> 256 writes at addresses 00..FF, truncated=1, word_count=256, done pulses once.
REQ-038 Random byte_valid gaps of 0..15 cycles (GAP_TIMEOUT=16) between bytes -> identical memory contents, timeout_err=0.
REQ-039 Byte 4A followed by 16 idle cycles -> timeout_err=1, no mem_we, return to IDLE, cpu_hold=0, no done pulse.
REQ-040 rst_n low after two words are written -> all outputs 0 asynchronously; a subsequent start followed by 12 34 F8 00 writes [00]=1234 and [01]=F800.
REQ-041 start asserted while in GET_LO -> no state or pointer change; the load completes normally.
